// File: rtl/disp_sched_pkg.sv
// Shared definitions for the display scheduler: FSM state encoding, the
// default dwell period and an index-width helper used for the round-robin
// pointer.
package disp_sched_pkg;

    typedef enum logic [1:0] {
        DS_IDLE    = 2'd0,
        DS_SHOW_LO = 2'd1,
        DS_SHOW_HI = 2'd2
    } ds_state_e;

    localparam logic [31:0] DISP_DWELL = 32'h003f_0000;

    // Width of an index into n requesters; never below 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_sched_rr_pick.sv
// Combinational round-robin picker (rr_pick) for the display scheduler.
// Picks the first set request bit at or after ptr, wrapping modulo NREQ,
// and reports it one-hot, as an index, and with an any-request flag.
module disp_sched_rr_pick
    import disp_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   winIdx,
    output logic            any
);

    int          idx;
    logic [IW-1:0] idxV;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        win    = '0;
        winIdx = '0;
        any    = 1'b0;
        idx    = 0;
        idxV   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idxV = IW'(idx);
            if (!any && req[idxV]) begin
                any        = 1'b1;
                win[idxV]  = 1'b1;
                winIdx     = idxV;
            end
        end
    end

endmodule

// File: rtl/disp_sched.sv
// Round-robin scheduler sharing the 4-digit seven-segment display between
// NREQ requesters. The winner's 32-bit value is latched and paged out as the
// low half then the high half, each for DWELL cycles.
//
// Optional build macro DISP_HOLD_EN: when defined, hold=1 freezes the dwell
// counter and the current page during a grant. When undefined, hold is ignored.
//
// state      | meaning
// -----------+------------------------------------------------------------
// DS_IDLE    | no grant; arbitrate among req starting at ptr
// DS_SHOW_LO | grant active, driver shows dispVal[15:0] (dispHi=0)
// DS_SHOW_HI | grant active, driver shows dispVal[31:16] (dispHi=1)
module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int          NREQ  = 4,
    parameter logic [31:0] DWELL = DISP_DWELL
) (
    input  logic              clkIn,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [32*NREQ-1:0] val,
    input  logic              hold,
    output logic [NREQ-1:0]   gnt,
    output logic [31:0]       dispVal,
    output logic              dispHi,
    output logic              busy,
    output logic              done
);

    localparam int          IW       = idx_w(NREQ);
    localparam logic [31:0] DWELL_M1 = DWELL - 32'd1;

    ds_state_e       state, stateNxt;
    logic [31:0]     cnt, cntNxt;
    logic [IW-1:0]   ptr, ptrNxt;
    logic [IW-1:0]   owner, ownerNxt;
    logic [NREQ-1:0] gntNxt;
    logic [31:0]     dispValNxt;
    logic            dispHiNxt;
    logic            busyNxt;
    logic            doneNxt;

    logic [NREQ-1:0] win;
    logic [IW-1:0]   winIdx;
    logic            anyReq;
    logic [31:0]     winVal;
    logic [IW-1:0]   ownerInc;
    logic            ownerReq;
    logic            holdAct;
    logic            dwellEnd;

`ifdef DISP_HOLD_EN
    assign holdAct = hold;
`else
    logic unusedHold;
    assign unusedHold = hold;
    assign holdAct    = 1'b0;
`endif

    disp_sched_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .win    (win),
        .winIdx (winIdx),
        .any    (anyReq)
    );

    assign ownerReq = req[owner];
    assign ownerInc = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
    assign dwellEnd = (cnt == DWELL_M1);

    // Select the value of the requester the picker chose.
    always_comb begin
        winVal = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                winVal = val[32*i +: 32];
            end
        end
    end

    // State and output registers; reset clears everything including dispVal.
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            state   <= DS_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            owner   <= '0;
            gnt     <= '0;
            dispVal <= '0;
            dispHi  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= stateNxt;
            cnt     <= cntNxt;
            ptr     <= ptrNxt;
            owner   <= ownerNxt;
            gnt     <= gntNxt;
            dispVal <= dispValNxt;
            dispHi  <= dispHiNxt;
            busy    <= busyNxt;
            done    <= doneNxt;
        end
    end

    // Next-state and next-output logic. Owner withdrawal is checked before
    // hold and dwell expiry so it always wins.
    always_comb begin
        stateNxt   = state;
        cntNxt     = cnt;
        ptrNxt     = ptr;
        ownerNxt   = owner;
        gntNxt     = gnt;
        dispValNxt = dispVal;
        dispHiNxt  = dispHi;
        busyNxt    = busy;
        doneNxt    = 1'b0;

        unique case (state)
            DS_IDLE: begin
                cntNxt    = '0;
                dispHiNxt = 1'b0;
                if (anyReq) begin
                    gntNxt     = win;
                    dispValNxt = winVal;
                    busyNxt    = 1'b1;
                    ownerNxt   = winIdx;
                    stateNxt   = DS_SHOW_LO;
                end else begin
                    gntNxt  = '0;
                    busyNxt = 1'b0;
                end
            end

            DS_SHOW_LO: begin
                if (!ownerReq) begin
                    stateNxt  = DS_IDLE;
                    gntNxt    = '0;
                    busyNxt   = 1'b0;
                    dispHiNxt = 1'b0;
                    cntNxt    = '0;
                    ptrNxt    = ownerInc;
                end else if (holdAct) begin
                    cntNxt = cnt;
                end else if (dwellEnd) begin
                    stateNxt  = DS_SHOW_HI;
                    dispHiNxt = 1'b1;
                    cntNxt    = '0;
                end else begin
                    cntNxt = cnt + 32'd1;
                end
            end

            DS_SHOW_HI: begin
                if (!ownerReq) begin
                    stateNxt  = DS_IDLE;
                    gntNxt    = '0;
                    busyNxt   = 1'b0;
                    dispHiNxt = 1'b0;
                    cntNxt    = '0;
                    ptrNxt    = ownerInc;
                end else if (holdAct) begin
                    cntNxt = cnt;
                end else if (dwellEnd) begin
                    stateNxt  = DS_IDLE;
                    gntNxt    = '0;
                    busyNxt   = 1'b0;
                    dispHiNxt = 1'b0;
                    doneNxt   = 1'b1;
                    cntNxt    = '0;
                    ptrNxt    = ownerInc;
                end else begin
                    cntNxt = cnt + 32'd1;
                end
            end

            default: begin
                stateNxt  = DS_IDLE;
                gntNxt    = '0;
                busyNxt   = 1'b0;
                dispHiNxt = 1'b0;
                cntNxt    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_disp_sched.sv
// Testbench for disp_sched with NREQ=4, DWELL=4. A passive monitor condenses
// every grant into a record (owner, latched value, length, low-page cycles,
// done on release, stability, idle gap before it); each scenario pushes the
// records it expects and compares them as the monitor produces them.
module tb_disp_sched;

    typedef struct packed {
        logic [3:0]  g;
        logic [31:0] v;
        logic [7:0]  len;
        logic [7:0]  lo;
        logic        doneSeen;
        logic        stable;
        logic [7:0]  gap;
    } rec_t;

    logic         clkIn;
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  v [4];
    logic [127:0] valBus;
    logic         hold;
    logic [3:0]   gnt;
    logic [31:0]  dispVal;
    logic         dispHi;
    logic         busy;
    logic         done;

    int   nCmp;
    int   nBad;
    int   doneCnt;
    rec_t obsQ [$];
    rec_t expQ [$];

    rec_t cur;
    bit   inGrant;
    bit   sawHi;
    int   idleCnt;

    assign valBus = {v[3], v[2], v[1], v[0]};

    disp_sched #(
        .NREQ  (4),
        .DWELL (32'd4)
    ) dut (
        .clkIn   (clkIn),
        .rst     (rst),
        .req     (req),
        .val     (valBus),
        .hold    (hold),
        .gnt     (gnt),
        .dispVal (dispVal),
        .dispHi  (dispHi),
        .busy    (busy),
        .done    (done)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got unfinished run want finished run");
        $fatal(1, "watchdog expired");
    end

    // Grant monitor: samples on the falling edge, emits one record per grant.
    initial begin
        inGrant = 0;
        sawHi   = 0;
        idleCnt = 0;
        doneCnt = 0;
        cur     = '0;
    end
    always @(negedge clkIn) begin
        if (gnt !== 4'b0000) begin
            if (!inGrant) begin
                inGrant      = 1;
                sawHi        = (dispHi === 1'b1);
                cur.g        = gnt;
                cur.v        = dispVal;
                cur.len      = 8'd1;
                cur.lo       = (dispHi === 1'b0) ? 8'd1 : 8'd0;
                cur.stable   = (busy === 1'b1) && (done === 1'b0) && (dispHi === 1'b0);
                cur.doneSeen = 1'b0;
                cur.gap      = 8'(idleCnt);
                idleCnt      = 0;
            end else begin
                cur.len = cur.len + 8'd1;
                if (dispHi === 1'b0) cur.lo = cur.lo + 8'd1;
                if (sawHi && dispHi !== 1'b1) cur.stable = 1'b0;
                if (dispHi === 1'b1) sawHi = 1;
                if (gnt !== cur.g || dispVal !== cur.v || busy !== 1'b1 || done !== 1'b0)
                    cur.stable = 1'b0;
            end
        end else begin
            if (inGrant) begin
                cur.doneSeen = done;
                if (busy !== 1'b0 || dispHi !== 1'b0) cur.stable = 1'b0;
                obsQ.push_back(cur);
                inGrant = 0;
                idleCnt = 1;
            end else begin
                idleCnt++;
            end
        end
        if (done === 1'b1) doneCnt++;
    end

    function automatic rec_t mk(input logic [3:0] g, input logic [31:0] val,
                                input int len, input int lo, input bit dn, input int gap);
        rec_t r;
        r.g        = g;
        r.v        = val;
        r.len      = 8'(len);
        r.lo       = 8'(lo);
        r.doneSeen = dn;
        r.stable   = 1'b1;
        r.gap      = 8'(gap);
        return r;
    endfunction

    task automatic wait_rec(input int budget, output rec_t r, output bit ok);
        ok = 0;
        r  = '0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clkIn);
            #1;
            if (obsQ.size() > 0) begin
                r  = obsQ.pop_front();
                ok = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        hold = 1'b0;
        for (int i = 0; i < 4; i++) v[i] = 32'h0;
        #2;
        rst = 1'b0;
        #10;
        nCmp++;
        if ({gnt, dispVal, dispHi, busy, done} !== 39'd0) begin
            nBad++;
            $display("FAIL reset_state: got gnt=%b val=%h hi=%b busy=%b done=%b want all 0",
                     gnt, dispVal, dispHi, busy, done);
        end
        @(negedge clkIn);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clkIn);
            #1;
            nCmp++;
            if ({gnt, dispVal, dispHi, busy, done} !== 39'd0) begin
                nBad++;
                $display("FAIL idle_no_req cycle %0d: got gnt=%b val=%h hi=%b busy=%b done=%b want all 0",
                         c, gnt, dispVal, dispHi, busy, done);
            end
        end
    endtask

    task automatic test_single();
        rec_t o, e;
        bit   ok;
        int   doneBefore;
        v[0] = 32'h0000_0A0A;
        v[1] = 32'h0000_1B1B;
        v[2] = 32'h1234_ABCD;
        v[3] = 32'h0000_3D3D;
        doneBefore = doneCnt;
        expQ.push_back(mk(4'b0100, 32'h1234_ABCD, 8, 4, 1, 255));
        req = 4'b0100;
        @(negedge clkIn);
        nCmp++;
        if (gnt !== 4'b0100) begin
            nBad++;
            $display("FAIL single_latency: got gnt=%b want 0100", gnt);
        end
        @(negedge clkIn);
        #1;
        v[2] = 32'hDEAD_BEEF;
        wait_rec(40, o, ok);
        req = 4'b0000;
        e = expQ.pop_front();
        if (e.gap == 8'd255) e.gap = o.gap;
        nCmp++;
        if (!ok) begin
            nBad++;
            $display("FAIL single_grant: got no record want grant to 0100");
        end else if (o !== e) begin
            nBad++;
            $display("FAIL single_grant: got %h want %h", o, e);
        end
        repeat (3) @(negedge clkIn);
        #1;
        nCmp++;
        if (doneCnt - doneBefore !== 1) begin
            nBad++;
            $display("FAIL single_done_pulse: got %0d done cycles want 1", doneCnt - doneBefore);
        end
    endtask

    task automatic test_back_to_back();
        rec_t o, e;
        bit   ok;
        logic [3:0] order [4];
        rst = 1'b0;
        #2;
        rst = 1'b1;
        v[0] = 32'hA0A0_0000;
        v[1] = 32'hB1B1_1111;
        v[2] = 32'hC2C2_2222;
        v[3] = 32'hD3D3_3333;
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b1000;
        order[3] = 4'b0001;
        expQ.push_back(mk(order[0], v[0], 8, 4, 1, 255));
        expQ.push_back(mk(order[1], v[1], 8, 4, 1, 1));
        expQ.push_back(mk(order[2], v[3], 8, 4, 1, 1));
        expQ.push_back(mk(order[3], v[0], 8, 4, 1, 1));
        @(negedge clkIn);
        #1;
        req = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            wait_rec(40, o, ok);
            if (i == 3) req = 4'b0000;
            e = expQ.pop_front();
            if (e.gap == 8'd255) e.gap = o.gap;
            nCmp++;
            if (!ok) begin
                nBad++;
                $display("FAIL b2b_grant%0d: got no record want gnt=%b", i, e.g);
            end else if (o !== e) begin
                nBad++;
                $display("FAIL b2b_grant%0d: got %h want %h", i, o, e);
            end
        end
        repeat (2) @(negedge clkIn);
        #1;
    endtask

    task automatic test_withdraw();
        rec_t o, e;
        bit   ok;
        int   doneBefore;
        v[1] = 32'h5555_1111;
        v[3] = 32'h7777_3333;
        doneBefore = doneCnt;
        expQ.push_back(mk(4'b0010, 32'h5555_1111, 6, 4, 0, 255));
        expQ.push_back(mk(4'b1000, 32'h7777_3333, 8, 4, 1, 1));
        req = 4'b0010;
        @(negedge clkIn);
        repeat (5) @(negedge clkIn);
        #1;
        req = 4'b1001;
        for (int i = 0; i < 2; i++) begin
            wait_rec(40, o, ok);
            if (i == 0) begin
                nCmp++;
                if (doneCnt !== doneBefore) begin
                    nBad++;
                    $display("FAIL withdraw_no_done: got %0d done cycles want 0", doneCnt - doneBefore);
                end
            end else begin
                req = 4'b0000;
            end
            e = expQ.pop_front();
            if (e.gap == 8'd255) e.gap = o.gap;
            nCmp++;
            if (!ok) begin
                nBad++;
                $display("FAIL withdraw_grant%0d: got no record want gnt=%b", i, e.g);
            end else if (o !== e) begin
                nBad++;
                $display("FAIL withdraw_grant%0d: got %h want %h", i, o, e);
            end
        end
        repeat (2) @(negedge clkIn);
        #1;
    endtask

    task automatic test_hold();
        rec_t o, e;
        bit   ok;
        v[0] = 32'h4321_8765;
`ifdef DISP_HOLD_EN
        expQ.push_back(mk(4'b0001, 32'h4321_8765, 13, 9, 1, 255));
`else
        expQ.push_back(mk(4'b0001, 32'h4321_8765, 8, 4, 1, 255));
`endif
        req = 4'b0001;
        @(negedge clkIn);
        #1;
        @(negedge clkIn);
        #1;
        hold = 1'b1;
        repeat (5) @(negedge clkIn);
        #1;
        hold = 1'b0;
        wait_rec(40, o, ok);
        req = 4'b0000;
        e = expQ.pop_front();
        if (e.gap == 8'd255) e.gap = o.gap;
        nCmp++;
        if (!ok) begin
            nBad++;
            $display("FAIL hold_grant: got no record want gnt=0001");
        end else if (o !== e) begin
            nBad++;
            $display("FAIL hold_grant: got %h want %h", o, e);
        end
        repeat (2) @(negedge clkIn);
        #1;
    endtask

    task automatic test_reset_mid();
        rec_t o, e;
        bit   ok;
        v[0] = 32'h0BAD_F00D;
        v[1] = 32'h0000_1111;
        expQ.push_back(mk(4'b0001, 32'h0BAD_F00D, 6, 4, 0, 255));
        req = 4'b0001;
        @(negedge clkIn);
        repeat (5) @(negedge clkIn);
        #1;
        rst = 1'b0;
        #1;
        nCmp++;
        if ({gnt, dispVal, dispHi, busy, done} !== 39'd0) begin
            nBad++;
            $display("FAIL reset_mid_async: got gnt=%b val=%h hi=%b busy=%b done=%b want all 0",
                     gnt, dispVal, dispHi, busy, done);
        end
        wait_rec(10, o, ok);
        e = expQ.pop_front();
        if (e.gap == 8'd255) e.gap = o.gap;
        nCmp++;
        if (!ok) begin
            nBad++;
            $display("FAIL reset_mid_cut: got no record want cut grant to 0001");
        end else if (o !== e) begin
            nBad++;
            $display("FAIL reset_mid_cut: got %h want %h", o, e);
        end
        v[0] = 32'h0000_0C0D;
        req  = 4'b0011;
        expQ.push_back(mk(4'b0001, 32'h0000_0C0D, 8, 4, 1, 255));
        #2;
        rst = 1'b1;
        wait_rec(40, o, ok);
        req = 4'b0000;
        e = expQ.pop_front();
        if (e.gap == 8'd255) e.gap = o.gap;
        nCmp++;
        if (!ok) begin
            nBad++;
            $display("FAIL reset_mid_regrant: got no record want grant to 0001");
        end else if (o !== e) begin
            nBad++;
            $display("FAIL reset_mid_regrant: got %h want %h", o, e);
        end
        repeat (3) @(negedge clkIn);
        #1;
    endtask

    initial begin
        nCmp = 0;
        nBad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_withdraw();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
